// File: rtl/bnn_layer_engine.sv
// bnn_layer_engine: one BNN layer (CONV or FCL) per iSTART.
// XNOR-popcount MAC over K words, threshold compare, OR max-pool over Q
// windows, N neuron bits packed into one WL-bit result word per position.

// One pool bit: OR-accumulates threshold results across pool windows.
module bnn_pool_lane (
   input  logic iCLK,
   input  logic iRSTn,
   input  logic iCLR,
   input  logic hit,       // this lane's neuron finished its K words
   input  logic first_q,   // first pool window: overwrite instead of OR
   input  logic bit_in,
   input  logic flush,     // word written this cycle, start next position clean
   output logic pool_upd
);
   logic pool_q;

   assign pool_upd = hit ? (first_q ? bit_in : (pool_q | bit_in)) : pool_q;

   // Pool bit register; flush clears it in the same cycle the word leaves.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn)      pool_q <= 1'b0;
      else if (iCLR)   pool_q <= 1'b0;
      else if (flush)  pool_q <= 1'b0;
      else             pool_q <= pool_upd;
   end
endmodule

module bnn_layer_engine #(
   parameter int WL  = 112,
   parameter int AW  = 9,
   parameter int WAW = 12,
   parameter int CW  = 11,
   parameter int PCW = 7
) (
   input  logic            iCLK,
   input  logic            iRSTn,
   input  logic            iCLR,
   input  logic            iSTART,
   input  logic [7:0]      iNWORDS,
   input  logic [6:0]      iNOUT,
   input  logic [2:0]      iPOOL,
   input  logic [AW-1:0]   iNPOS,
   input  logic [AW-1:0]   iRD_BASE,
   input  logic [AW-1:0]   iWR_BASE,
   input  logic [WAW-1:0]  iW_BASE,
   output logic [AW-1:0]   oACT_ADDR,
   output logic            oACT_RDEN,
   input  logic [WL-1:0]   iACT_DATA,
   output logic [WAW-1:0]  oW_ADDR,
   input  logic [WL-1:0]   iW_DATA,
   output logic [6:0]      oTH_ADDR,
   input  logic [CW-1:0]   iTH_DATA,
   output logic [AW-1:0]   oWR_ADDR,
   output logic [WL-1:0]   oWR_DATA,
   output logic            oWR_EN,
   output logic            oBUSY,
   output logic            oDONE
);
   localparam int SW = CW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   // Per-tuple control that travels alongside the data pipeline.
   typedef struct packed {
      logic       first_k;
      logic       last_k;
      logic       first_q;
      logic       flush;    // last k of last neuron of last window: emit word
      logic [6:0] n;
   } meta_t;

   state_t          state, state_n;
   logic            done_q, done_n, start_run;
   logic [1:0]      drain_cnt;

   logic [7:0]      cfg_k;
   logic [6:0]      cfg_n;
   logic [2:0]      cfg_q;
   logic [AW-1:0]   cfg_p;
   logic [WAW-1:0]  cfg_wbase;

   logic [7:0]      k_cnt;
   logic [6:0]      n_cnt;
   logic [2:0]      q_cnt;
   logic [AW-1:0]   p_cnt;
   logic [AW-1:0]   act_row;   // RD_BASE + (p*Q+q)*K, stepped by K
   logic [WAW-1:0]  w_row;     // W_BASE + n*K, stepped by K
   logic [AW-1:0]   wr_ptr;

   logic            issue, k_last, n_last, q_last, p_last, last_tuple, cfg_zero;

   logic [2:1]      vld_pipe;
   meta_t           s1, s2;
   logic [PCW-1:0]  s2_pc;
   logic [CW-1:0]   s2_th;
   logic [CW-1:0]   acc, acc_sat;
   logic [SW-1:0]   sum_raw;
   logic            th_bit, pool_en, wr_fire;
   logic [WL-1:0]   pool_upd;

   function automatic logic [PCW-1:0] popcnt(input logic [WL-1:0] v);
      logic [PCW-1:0] c;
      c = '0;
      for (int i = 0; i < WL; i++) c = c + PCW'(v[i]);
      return c;
   endfunction

   assign issue      = (state == S_RUN);
   assign k_last     = (k_cnt == cfg_k - 8'd1);
   assign n_last     = (n_cnt == cfg_n - 7'd1);
   assign q_last     = (q_cnt == cfg_q - 3'd1);
   assign p_last     = (p_cnt == cfg_p - AW'(1));
   assign last_tuple = k_last & n_last & q_last & p_last;
   assign cfg_zero   = (iNWORDS == '0) | (iNOUT == '0) | (iPOOL == '0) | (iNPOS == '0);

   assign oACT_RDEN = issue;
   assign oACT_ADDR = issue ? act_row + AW'(k_cnt) : '0;
   assign oW_ADDR   = issue ? w_row + WAW'(k_cnt) : '0;
   assign oTH_ADDR  = issue ? n_cnt : '0;
   assign oBUSY     = (state != S_IDLE);
   assign oDONE     = done_q;

   // FSM state, drain counter and done pulse registers.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state <= S_IDLE; done_q <= 1'b0; drain_cnt <= '0;
      end else if (iCLR) begin
         state <= S_IDLE; done_q <= 1'b0; drain_cnt <= '0;
      end else begin
         state     <= state_n;
         done_q    <= done_n;
         drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : '0;
      end
   end

   // Next-state: a zero-sized layer completes straight from IDLE.
   always_comb begin
      state_n   = state;
      done_n    = 1'b0;
      start_run = 1'b0;
      case (state)
         S_IDLE: if (iSTART) begin
            if (cfg_zero) done_n = 1'b1;
            else begin state_n = S_RUN; start_run = 1'b1; end
         end
         S_RUN:   if (last_tuple) state_n = S_DRAIN;
         S_DRAIN: if (drain_cnt == 2'd2) begin state_n = S_IDLE; done_n = 1'b1; end
         default: state_n = S_IDLE;
      endcase
   end

   // Config latch and (p,q,n,k) loop counters, k innermost.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn || iCLR) begin
         cfg_k <= '0; cfg_n <= '0; cfg_q <= '0; cfg_p <= '0; cfg_wbase <= '0;
         k_cnt <= '0; n_cnt <= '0; q_cnt <= '0; p_cnt <= '0;
         act_row <= '0; w_row <= '0;
      end else if (start_run) begin
         cfg_k <= iNWORDS; cfg_n <= iNOUT; cfg_q <= iPOOL; cfg_p <= iNPOS;
         cfg_wbase <= iW_BASE;
         k_cnt <= '0; n_cnt <= '0; q_cnt <= '0; p_cnt <= '0;
         act_row <= iRD_BASE; w_row <= iW_BASE;
      end else if (issue) begin
         if (!k_last) k_cnt <= k_cnt + 8'd1;
         else begin
            k_cnt <= '0;
            if (!n_last) begin
               n_cnt <= n_cnt + 7'd1;
               w_row <= w_row + WAW'(cfg_k);
            end else begin
               n_cnt   <= '0;
               w_row   <= cfg_wbase;
               act_row <= act_row + AW'(cfg_k);
               if (!q_last) q_cnt <= q_cnt + 3'd1;
               else begin
                  q_cnt <= '0;
                  p_cnt <= p_cnt + AW'(1);
               end
            end
         end
      end
   end

   // Pipeline: stage 1 popcount of XNOR, stage 2 accumulate and compare.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn || iCLR) begin
         vld_pipe <= '0; s1 <= '0; s2 <= '0; s2_pc <= '0; s2_th <= '0; acc <= '0;
      end else begin
         vld_pipe   <= {vld_pipe[1], issue};
         s1.first_k <= (k_cnt == '0);
         s1.last_k  <= k_last;
         s1.first_q <= (q_cnt == '0);
         s1.flush   <= k_last & n_last & q_last;
         s1.n       <= n_cnt;
         s2         <= s1;
         s2_pc      <= popcnt(~(iACT_DATA ^ iW_DATA));
         s2_th      <= iTH_DATA;
         if (vld_pipe[2]) acc <= acc_sat;
      end
   end

   // Saturating accumulate; the compare uses the sum including this word.
   assign sum_raw = (s2.first_k ? '0 : {1'b0, acc}) + SW'(s2_pc);
   assign acc_sat = sum_raw[CW] ? '1 : sum_raw[CW-1:0];
   assign th_bit  = (acc_sat >= s2_th);
   assign pool_en = vld_pipe[2] & s2.last_k;
   assign wr_fire = vld_pipe[2] & s2.flush;

   for (genvar i = 0; i < WL; i++) begin : g_lane
      bnn_pool_lane u_lane (
         .iCLK    (iCLK),
         .iRSTn   (iRSTn),
         .iCLR    (iCLR),
         .hit     (pool_en && (s2.n == 7'(i))),
         .first_q (s2.first_q),
         .bit_in  (th_bit),
         .flush   (wr_fire),
         .pool_upd(pool_upd[i])
      );
   end

   // Result write port; outputs idle at zero between words.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn || iCLR) begin
         oWR_EN <= 1'b0; oWR_DATA <= '0; oWR_ADDR <= '0; wr_ptr <= '0;
      end else begin
         oWR_EN   <= wr_fire;
         oWR_DATA <= wr_fire ? pool_upd : '0;
         oWR_ADDR <= wr_fire ? wr_ptr : '0;
         if (start_run)    wr_ptr <= iWR_BASE;
         else if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      end
   end
endmodule

// File: tb/tb_bnn_layer_engine.sv
// Directed bench for bnn_layer_engine with memory models and a write scoreboard.
module tb_bnn_layer_engine;
   localparam int WL = 112, AW = 9, WAW = 12, CW = 11, PCW = 7;

   logic            clk = 1'b0, rstn = 1'b0, clr = 1'b0, start = 1'b0;
   logic [7:0]      nwords = '0;
   logic [6:0]      nout = '0;
   logic [2:0]      pool = '0;
   logic [AW-1:0]   npos = '0, rdb = '0, wrb = '0;
   logic [WAW-1:0]  wb = '0;
   logic [AW-1:0]   act_addr, wr_addr;
   logic            act_rden, wr_en, busy, done;
   logic [WL-1:0]   act_d, w_d, wr_data;
   logic [WAW-1:0]  w_addr;
   logic [6:0]      th_addr;
   logic [CW-1:0]   th_d;

   logic [WL-1:0]   act_mem [0:511];
   logic [WL-1:0]   w_rom   [0:4095];
   logic [CW-1:0]   th_rom  [0:127];

   typedef struct {logic [AW-1:0] addr; logic [WL-1:0] data;} exp_t;
   exp_t sb_q[$];

   int checks = 0, failures = 0;

   bnn_layer_engine #(.WL(WL), .AW(AW), .WAW(WAW), .CW(CW), .PCW(PCW)) dut (
      .iCLK(clk), .iRSTn(rstn), .iCLR(clr), .iSTART(start),
      .iNWORDS(nwords), .iNOUT(nout), .iPOOL(pool), .iNPOS(npos),
      .iRD_BASE(rdb), .iWR_BASE(wrb), .iW_BASE(wb),
      .oACT_ADDR(act_addr), .oACT_RDEN(act_rden), .iACT_DATA(act_d),
      .oW_ADDR(w_addr), .iW_DATA(w_d), .oTH_ADDR(th_addr), .iTH_DATA(th_d),
      .oWR_ADDR(wr_addr), .oWR_DATA(wr_data), .oWR_EN(wr_en),
      .oBUSY(busy), .oDONE(done)
   );

   always #5 clk = ~clk;

   // One-cycle-latency memories.
   always @(posedge clk) begin
      act_d <= act_mem[act_addr];
      w_d   <= w_rom[w_addr];
      th_d  <= th_rom[th_addr];
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every write must match the oldest expected word.
   always @(negedge clk) begin
      if (wr_en) begin
         if (sb_q.size() == 0) chk("unexpected_write", {wr_addr, wr_data}, '0);
         else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
         end
      end
   end

   function automatic logic [WL-1:0] rnd_word();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[WL-1:0];
   endfunction

   task automatic set_th(input int k);
      for (int i = 0; i < 128; i++) th_rom[i] = CW'($urandom_range(50 * k, 62 * k));
   endtask

   // Reference: straight nested loops over the layer definition.
   task automatic push_layer(input int k, n, q, p, r, w, wbs);
      for (int pi = 0; pi < p; pi++) begin
         exp_t e;
         e.data = '0;
         for (int qi = 0; qi < q; qi++)
            for (int ni = 0; ni < n; ni++) begin
               int acc;
               acc = 0;
               for (int ki = 0; ki < k; ki++) begin
                  logic [WL-1:0] a, ww;
                  a  = act_mem[(r + (pi * q + qi) * k + ki) % 512];
                  ww = w_rom[(wbs + ni * k + ki) % 4096];
                  acc = acc + $countones(~(a ^ ww));
                  if (acc > 2047) acc = 2047;
               end
               if (acc >= int'(th_rom[ni])) e.data[ni] = 1'b1;
            end
         e.addr = AW'((w + pi) % 512);
         sb_q.push_back(e);
      end
   endtask

   task automatic run_layer(input string tag, input int k, n, q, p, r, w, wbs,
                            input bit pulse_mid, output logic [WL-1:0] last_data);
      bit zero;
      int t, nwr, ndone, done_cyc, first_wr, last_wr;
      zero = (k == 0) || (n == 0) || (q == 0) || (p == 0);
      t = zero ? 0 : p * q * n * k;
      nwr = 0; ndone = 0; done_cyc = 0; first_wr = 0; last_wr = 0; last_data = '0;
      @(negedge clk);
      nwords = 8'(k); nout = 7'(n); pool = 3'(q); npos = AW'(p);
      rdb = AW'(r); wrb = AW'(w); wb = WAW'(wbs); start = 1'b1;
      if (!zero) push_layer(k, n, q, p, r, w, wbs);
      for (int j = 1; j <= t + 10; j++) begin
         @(negedge clk);
         if (j == 1) begin
            start = 1'b0;
            if (!zero) begin
               chk({tag, "_busy"}, busy, 1'b1);
               chk({tag, "_act0"}, {act_rden, act_addr}, {1'b1, AW'(r)});
            end
            nwords = 8'($urandom); nout = 7'($urandom); pool = 3'($urandom);
            npos = AW'($urandom); rdb = AW'($urandom); wrb = AW'($urandom);
         end
         if (pulse_mid && j == 2) start = 1'b1;
         if (pulse_mid && j == 3) start = 1'b0;
         if (wr_en) begin
            nwr++;
            if (first_wr == 0) first_wr = j;
            last_wr = j;
            last_data = wr_data;
         end
         if (done) begin ndone++; done_cyc = j; end
      end
      chk({tag, "_ndone"}, ndone, 1);
      chk({tag, "_done_cyc"}, done_cyc, zero ? 1 : t + 4);
      chk({tag, "_nwr"}, nwr, zero ? 0 : p);
      if (!zero) begin
         chk({tag, "_first_wr"}, first_wr, q * n * k + 3);
         chk({tag, "_last_wr"}, last_wr, t + 3);
      end
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      logic [WL-1:0] ones, d;
      int nw, nd;
      ones = '1;
      for (int i = 0; i < 512; i++)  act_mem[i] = rnd_word();
      for (int i = 0; i < 4096; i++) w_rom[i] = rnd_word();
      set_th(1);

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ctl", {wr_en, done, busy, act_rden}, 4'b0);
      chk("rst_data", wr_data, '0);
      chk("rst_addr", {act_addr, w_addr, th_addr, wr_addr}, '0);
      rstn = 1'b1;

      // Single neuron, exact threshold boundary
      act_mem[10] = ones; w_rom[100] = ones; th_rom[0] = 112;
      run_layer("t1", 1, 1, 1, 1, 10, 20, 100, 1'b0, d);
      chk("t1_bit", d, 1);
      th_rom[0] = 113;
      run_layer("t2a", 1, 1, 1, 1, 10, 20, 100, 1'b0, d);
      chk("t2a_bit", d, 0);
      for (int i = 0; i < 3; i++) begin act_mem[10 + i] = ones; w_rom[100 + i] = ones; end
      th_rom[0] = 336;
      run_layer("t2b", 3, 1, 1, 1, 10, 20, 100, 1'b0, d);
      chk("t2b_bit", d, 1);
      th_rom[0] = 337;
      run_layer("t2c", 3, 1, 1, 1, 10, 20, 100, 1'b0, d);
      chk("t2c_bit", d, 0);

      // Accumulator saturates at 2047 rather than wrapping
      for (int i = 0; i < 20; i++) begin act_mem[30 + i] = ones; w_rom[200 + i] = ones; end
      th_rom[0] = 2047;
      run_layer("sat", 20, 1, 1, 1, 30, 21, 200, 1'b0, d);
      chk("sat_bit", d, 1);

      // Max-pool: neuron0 passes only in window 2, neuron1 never
      act_mem[60] = '0; act_mem[61] = '0; act_mem[62] = ones; act_mem[63] = '0;
      w_rom[300] = ones; w_rom[301] = ones; th_rom[0] = 112; th_rom[1] = 113;
      run_layer("t3", 1, 2, 4, 1, 60, 22, 300, 1'b0, d);
      chk("t3_word", d, 1);

      // Back-to-back positions from the upper bank
      set_th(1);
      run_layer("t4", 1, 1, 1, 3, 252, 0, 400, 1'b0, d);

      // Mixed random layer, address wrap, full-width word
      set_th(3);
      run_layer("rnd", 3, 5, 4, 2, 100, 30, 500, 1'b0, d);
      set_th(2);
      run_layer("wrap", 2, 2, 1, 2, 510, 511, 4094, 1'b0, d);
      set_th(1);
      run_layer("wide", 1, 112, 1, 1, 200, 50, 1000, 1'b0, d);

      // Abort mid-RUN
      @(negedge clk);
      nwords = 2; nout = 3; pool = 2; npos = 2; rdb = 5; wrb = 40; wb = 700; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("clr_busy_before", busy, 1'b1);
      clr = 1'b1;
      @(negedge clk);
      chk("clr_ctl", {wr_en, done, busy, act_rden}, 4'b0);
      chk("clr_addr", {act_addr, w_addr, th_addr, wr_addr}, '0);
      chk("clr_data", wr_data, '0);
      clr = 1'b0;
      nw = 0; nd = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (wr_en) nw++;
         if (done) nd++;
      end
      chk("clr_no_wr", nw, 0);
      chk("clr_no_done", nd, 0);
      set_th(2);
      run_layer("post_clr", 2, 3, 2, 2, 5, 40, 700, 1'b0, d);

      // Zero-sized layer, then iSTART pulsed during RUN
      run_layer("zero", 1, 1, 1, 0, 0, 0, 0, 1'b0, d);
      run_layer("restart", 2, 2, 2, 2, 300, 60, 1500, 1'b1, d);

      chk("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
